// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its wide operand sequencer:
// op encodings, slice width, sequencer FSM states and op classification helpers.
package alu_pkg;

    localparam int unsigned SLICE_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seq_state_e;

    // LT and EQ compare whole operands and cannot be computed slice by slice.
    function automatic logic op_supported(input logic [2:0] op);
        return (op != OP_LT) && (op != OP_EQ);
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_wide_seq_if.sv
// Command and response handshake channels of the wide ALU sequencer.
// master is the requester side, slave is the sequencer side.
interface alu_wide_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_cin;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_overflow;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cin, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_err
    );

endinterface

// File: rtl/alu_wide_seq.sv
// Wide operand sequencer: feeds a 4-bit combinational ALU one slice per cycle, LSB first,
// chaining carry for ADD/SUB, and returns the assembled result over a valid/ready channel.
module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_wide_seq_if.slave      bus,
    output logic [2:0]         alu_op,
    output logic               alu_in_c,
    output logic [SLICE_W-1:0] alu_in_x,
    output logic [SLICE_W-1:0] alu_in_y,
    input  logic [SLICE_W-1:0] alu_out_s,
    input  logic               alu_out_c,
    input  logic               alu_zero,
    input  logic               alu_overflow
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       op_q, op_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    int unsigned      lsb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            op_q     <= '0;
            cin_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            cin_q    <= cin_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        op_d          = op_q;
        cin_d         = cin_q;
        a_d           = a_q;
        b_d           = b_q;
        result_d      = result_q;
        carry_d       = carry_q;
        zero_d        = zero_q;
        ovf_d         = ovf_q;
        err_d         = err_q;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        alu_op        = '0;
        alu_in_c      = 1'b0;
        alu_in_x      = '0;
        alu_in_y      = '0;
        lsb           = 32'(idx_q) * SLICE_W;

        unique case (state_q)
            StIdle: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    op_d     = bus.cmd_op;
                    cin_d    = bus.cmd_cin;
                    a_d      = bus.cmd_a;
                    b_d      = bus.cmd_b;
                    result_d = '0;
                    carry_d  = 1'b0;
                    zero_d   = 1'b1;
                    ovf_d    = 1'b0;
                    idx_d    = '0;
                    if (op_supported(bus.cmd_op)) begin
                        err_d   = 1'b0;
                        state_d = StRun;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                alu_op   = op_q;
                alu_in_x = a_q[lsb +: SLICE_W];
                alu_in_y = b_q[lsb +: SLICE_W];
                // Slice 0 takes the command carry-in, later slices ripple the stored carry.
                if (op_is_arith(op_q)) begin
                    alu_in_c = (idx_q == '0) ? cin_q : carry_q;
                end
                result_d[lsb +: SLICE_W] = alu_out_s;
                carry_d = alu_out_c;
                zero_d  = zero_q & alu_zero;
                ovf_d   = alu_overflow;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.rsp_result   = result_q;
    assign bus.rsp_carry    = carry_q;
    assign bus.rsp_zero     = zero_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.rsp_err      = err_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: a behavioural 4-bit ALU closes the loop, and each response is
// compared with whole-width arithmetic computed directly from the operands.
module tb_alu_wide_seq;
    import alu_pkg::*;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NSLICE = WIDTH / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_wide_seq_if #(.WIDTH(WIDTH)) bus ();

    logic [2:0] alu_op;
    logic       alu_in_c;
    logic [3:0] alu_in_x;
    logic [3:0] alu_in_y;
    logic [3:0] alu_out_s;
    logic       alu_out_c;
    logic       alu_zero;
    logic       alu_overflow;

    alu_wide_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_op       (alu_op),
        .alu_in_c     (alu_in_c),
        .alu_in_x     (alu_in_x),
        .alu_in_y     (alu_in_y),
        .alu_out_s    (alu_out_s),
        .alu_out_c    (alu_out_c),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow)
    );

    // Behavioural 4-bit ALU standing in for the parent's instance.
    logic [4:0] sum;
    logic [3:0] ym;
    always_comb begin
        ym           = ~alu_in_y;
        sum          = '0;
        alu_out_s    = '0;
        alu_out_c    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sum          = {1'b0, alu_in_x} + {1'b0, alu_in_y} + {4'b0, alu_in_c};
                alu_out_s    = sum[3:0];
                alu_out_c    = sum[4];
                alu_overflow = (alu_in_x[3] == alu_in_y[3]) && (sum[3] != alu_in_x[3]);
            end
            OP_SUB: begin
                sum          = {1'b0, alu_in_x} + {1'b0, ym} + {4'b0, alu_in_c};
                alu_out_s    = sum[3:0];
                alu_out_c    = sum[4];
                alu_overflow = (alu_in_x[3] == ym[3]) && (sum[3] != alu_in_x[3]);
            end
            OP_NOT:  alu_out_s = ~alu_in_x;
            OP_AND:  alu_out_s = alu_in_x & alu_in_y;
            OP_OR:   alu_out_s = alu_in_x | alu_in_y;
            OP_XOR:  alu_out_s = alu_in_x ^ alu_in_y;
            default: alu_out_s = '0;
        endcase
        alu_zero = (alu_out_s == 4'h0);
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Whole-width reference: plain 17-bit arithmetic on the full operands.
    task automatic model(input logic [2:0] op, input logic cin, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] res, output logic c,
                         output logic z, output logic v, output logic err);
        logic [16:0] s;
        logic [15:0] bb;
        res = '0; c = 1'b0; v = 1'b0; err = 1'b0;
        bb  = (op == OP_SUB) ? ~b : b;
        case (op)
            OP_ADD, OP_SUB: begin
                s   = {1'b0, a} + {1'b0, bb} + {16'b0, cin};
                res = s[15:0];
                c   = s[16];
                v   = (a[15] == bb[15]) && (res[15] != a[15]);
            end
            OP_NOT:  res = ~a;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: err = 1'b1;
        endcase
        z = (res == 16'h0);
    endtask

    // Carry entering slice i is the carry out of the low 4*i bits of the full sum.
    function automatic logic slice_cin(input logic [2:0] op, input logic cin,
                                       input logic [15:0] a, input logic [15:0] b, input int i);
        logic [31:0] aa, bb, m;
        if (op != OP_ADD && op != OP_SUB) return 1'b0;
        if (i == 0) return cin;
        aa = {16'b0, a};
        bb = (op == OP_SUB) ? {16'b0, ~b} : {16'b0, b};
        m  = (32'd1 << (4 * i)) - 1;
        return 1'((((aa & m) + (bb & m) + {31'b0, cin}) >> (4 * i)) & 32'd1);
    endfunction

    task automatic offer(input logic [2:0] op, input logic cin, input logic [15:0] a,
                         input logic [15:0] b);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_cin   = cin;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        check_eq("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic cin, input logic [15:0] a,
                           input logic [15:0] b, input int stall);
        logic [15:0] e_res, snap_res;
        logic        e_c, e_z, e_v, e_err;
        logic [4:0]  snap_flags;
        int          n;
        logic        seen;
        model(op, cin, a, b, e_res, e_c, e_z, e_v, e_err);
        offer(op, cin, a, b);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (e_err) begin
                check_eq("err_alu_x", {28'b0, alu_in_x}, 32'd0);
                check_eq("err_alu_y", {28'b0, alu_in_y}, 32'd0);
            end
            if (bus.rsp_valid) begin
                seen = 1'b1;
            end else if (!e_err && n <= int'(NSLICE)) begin
                check_eq("alu_op", {29'b0, alu_op}, {29'b0, op});
                check_eq("alu_in_x", {28'b0, alu_in_x}, 32'((a >> (4 * (n - 1))) & 16'hF));
                check_eq("alu_in_y", {28'b0, alu_in_y}, 32'((b >> (4 * (n - 1))) & 16'hF));
                check_eq("alu_in_c", {31'b0, alu_in_c},
                         {31'b0, slice_cin(op, cin, a, b, n - 1)});
                check_eq("cmd_ready_busy", {31'b0, bus.cmd_ready}, 32'd0);
            end
            // A command offered while busy must be ignored.
            if (!e_err && n == 1) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 3'($urandom_range(0, 7));
                bus.cmd_a     = 16'($urandom);
            end
            if (n == 2) bus.cmd_valid = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        check_eq("latency", n, e_err ? 32'd1 : 32'(NSLICE + 1));
        if (seen) begin
            snap_res   = bus.rsp_result;
            snap_flags = {bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_overflow,
                          bus.rsp_err};
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                check_eq("hold_result", {16'b0, bus.rsp_result}, {16'b0, snap_res});
                check_eq("hold_flags", {27'b0, bus.rsp_valid, bus.rsp_carry, bus.rsp_zero,
                                        bus.rsp_overflow, bus.rsp_err}, {27'b0, snap_flags});
                check_eq("hold_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
            end
            check_eq("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e_err});
            check_eq("rsp_result", {16'b0, bus.rsp_result}, {16'b0, e_res});
            check_eq("rsp_zero", {31'b0, bus.rsp_zero}, {31'b0, e_z});
            if (!e_err) begin
                check_eq("rsp_carry", {31'b0, bus.rsp_carry}, {31'b0, e_c});
                check_eq("rsp_overflow", {31'b0, bus.rsp_overflow}, {31'b0, e_v});
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
            @(negedge clk);
            check_eq("back_to_idle", {30'b0, bus.cmd_ready, bus.rsp_valid}, 32'b10);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_hs"}, {30'b0, bus.cmd_ready, bus.rsp_valid}, 32'b10);
        check_eq({tag, "_result"}, {16'b0, bus.rsp_result}, 32'd0);
        check_eq({tag, "_flags"}, {28'b0, bus.rsp_carry, bus.rsp_zero, bus.rsp_overflow,
                                   bus.rsp_err}, 32'd0);
        check_eq({tag, "_alu"}, {20'b0, alu_op, alu_in_c, alu_in_x, alu_in_y}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_cin   = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_cmd(OP_ADD, 1'b0, 16'h00FF, 16'h0001, 0);
        run_cmd(OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 0);
        run_cmd(OP_SUB, 1'b1, 16'h8000, 16'h0001, 0);
        run_cmd(OP_XOR, 1'b1, 16'hA5A5, 16'hA5A5, 0);
        run_cmd(OP_LT,  1'b0, 16'h1234, 16'h5678, 0);
        run_cmd(OP_EQ,  1'b1, 16'hFFFF, 16'hFFFF, 2);
        run_cmd(OP_ADD, 1'b1, 16'h7FFF, 16'h0000, 3);

        // Reset while slice 2 is on the ALU, then a clean command.
        offer(OP_ADD, 1'b0, 16'h1357, 16'h2468);
        repeat (3) @(negedge clk);
        check_eq("mid_run_x", {28'b0, alu_in_x}, 32'h3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(OP_SUB, 1'b1, 16'h1234, 16'h1234, 1);

        for (int i = 0; i < 40; i++) begin
            run_cmd(3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
